// File: rtl/i2s_rx.sv
// ---------------------------------------------------------------------------
// i2s_rx -- Philips-format I2S receiver (slave side).
//
// Synchronises externally supplied BCLK / LRCLK / SD into the clk domain,
// detects BCLK rising edges and deserialises one sample per LRCLK slot
// (MSB one BCLK after the LRCLK edge). A left slot followed by a right slot
// produces one aligned stereo pair with a single-cycle sample_valid pulse.
// Each closed slot must have exactly SLOT_BITS BCLK periods, otherwise a
// slot_err pulse is raised and lock is dropped.
//
// Ports
//   clk          in   system clock (>= 4x BCLK)
//   rst          in   synchronous, active-high reset
//   bclk         in   I2S bit clock (asynchronous to clk)
//   lrclk        in   word select, 0 = left, 1 = right
//   sd           in   serial data
//   sample_l     out  [DATA_WIDTH-1:0] left sample, raw two's complement bits
//   sample_r     out  [DATA_WIDTH-1:0] right sample, raw two's complement bits
//   sample_valid out  1-cycle pulse, sample_l/sample_r updated together
//   slot_err     out  1-cycle pulse, closed slot had the wrong BCLK count
//   locked       out  high after the first good pair until slot_err or rst
// ---------------------------------------------------------------------------
module i2s_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SLOT_BITS   = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bclk,
  input  logic                  lrclk,
  input  logic                  sd,
  output logic [DATA_WIDTH-1:0] sample_l,
  output logic [DATA_WIDTH-1:0] sample_r,
  output logic                  sample_valid,
  output logic                  slot_err,
  output logic                  locked
);

  localparam int CW = $clog2(SLOT_BITS) + 1;

  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_BITS - 1);
  localparam logic [CW-1:0] DW_CNT    = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  // Synchronisers: all three pins get the same delay so their relative
  // alignment (data valid around the BCLK rise) is preserved.
  logic [SYNC_STAGES-1:0] bclk_sync_q;
  logic [SYNC_STAGES-1:0] lrclk_sync_q;
  logic [SYNC_STAGES-1:0] sd_sync_q;
  logic                   bclk_q;

  logic bclk_s;
  logic lrclk_s;
  logic sd_s;
  logic rise_s;
  logic boundary_s;
  logic [DATA_WIDTH:0] shift_s;

  // Deserialiser and output state.
  logic                  lr_prev_q,    lr_prev_d;
  logic                  armed_q,      armed_d;
  logic                  have_left_q,  have_left_d;
  logic [CW-1:0]         bit_cnt_q,    bit_cnt_d;
  logic [DATA_WIDTH-1:0] shreg_q,      shreg_d;
  logic [DATA_WIDTH-1:0] hold_l_q,     hold_l_d;
  logic [DATA_WIDTH-1:0] sample_l_q,   sample_l_d;
  logic [DATA_WIDTH-1:0] sample_r_q,   sample_r_d;
  logic                  valid_q,      valid_d;
  logic                  err_q,        err_d;
  logic                  locked_q,     locked_d;

  assign bclk_s  = bclk_sync_q[SYNC_STAGES-1];
  assign lrclk_s = lrclk_sync_q[SYNC_STAGES-1];
  assign sd_s    = sd_sync_q[SYNC_STAGES-1];

  assign rise_s     = bclk_s & ~bclk_q;
  // The rise right after an LRCLK change still carries the old slot's last bit.
  assign boundary_s = rise_s & (lrclk_s != lr_prev_q);
  // One wider than shreg so the DATA_WIDTH==1 case needs no special slicing.
  assign shift_s    = {shreg_q, sd_s};

  // Next-state logic: everything advances only on a synchronised BCLK rise.
  always_comb begin
    lr_prev_d   = lr_prev_q;
    armed_d     = armed_q;
    have_left_d = have_left_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    hold_l_d    = hold_l_q;
    sample_l_d  = sample_l_q;
    sample_r_d  = sample_r_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    locked_d    = locked_q;

    if (rise_s) begin
      lr_prev_d = lrclk_s;
      if (boundary_s) begin
        // Closing slot channel is lr_prev_q (0 = left, 1 = right).
        if (!armed_q) begin
          // First boundary after reset only aligns us to a slot start.
          armed_d = 1'b1;
        end else if (bit_cnt_q != SLOT_LAST) begin
          err_d       = 1'b1;
          have_left_d = 1'b0;
          locked_d    = 1'b0;
        end else if (!lr_prev_q) begin
          hold_l_d    = shreg_q;
          have_left_d = 1'b1;
        end else if (have_left_q) begin
          sample_l_d  = hold_l_q;
          sample_r_d  = shreg_q;
          valid_d     = 1'b1;
          locked_d    = 1'b1;
          have_left_d = 1'b0;
        end else begin
          // Good right slot with no matching left: dropped silently.
          have_left_d = 1'b0;
        end
        bit_cnt_d = {CW{1'b0}};
        shreg_d   = {DATA_WIDTH{1'b0}};
      end else begin
        // Bits beyond DATA_WIDTH are slot padding: counted, not stored.
        if (bit_cnt_q < DW_CNT) begin
          shreg_d = shift_s[DATA_WIDTH-1:0];
        end else begin
          shreg_d = shreg_q;
        end
        if (bit_cnt_q != CNT_MAX) begin
          bit_cnt_d = bit_cnt_q + CNT_ONE;
        end else begin
          bit_cnt_d = bit_cnt_q;
        end
      end
    end else begin
      lr_prev_d = lr_prev_q;
    end
  end

  // State registers, synchronisers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bclk_sync_q  <= {SYNC_STAGES{1'b0}};
      lrclk_sync_q <= {SYNC_STAGES{1'b0}};
      sd_sync_q    <= {SYNC_STAGES{1'b0}};
      bclk_q       <= 1'b0;
      lr_prev_q    <= 1'b0;
      armed_q      <= 1'b0;
      have_left_q  <= 1'b0;
      bit_cnt_q    <= {CW{1'b0}};
      shreg_q      <= {DATA_WIDTH{1'b0}};
      hold_l_q     <= {DATA_WIDTH{1'b0}};
      sample_l_q   <= {DATA_WIDTH{1'b0}};
      sample_r_q   <= {DATA_WIDTH{1'b0}};
      valid_q      <= 1'b0;
      err_q        <= 1'b0;
      locked_q     <= 1'b0;
    end else begin
      bclk_sync_q  <= {bclk_sync_q[SYNC_STAGES-2:0], bclk};
      lrclk_sync_q <= {lrclk_sync_q[SYNC_STAGES-2:0], lrclk};
      sd_sync_q    <= {sd_sync_q[SYNC_STAGES-2:0], sd};
      bclk_q       <= bclk_s;
      lr_prev_q    <= lr_prev_d;
      armed_q      <= armed_d;
      have_left_q  <= have_left_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      hold_l_q     <= hold_l_d;
      sample_l_q   <= sample_l_d;
      sample_r_q   <= sample_r_d;
      valid_q      <= valid_d;
      err_q        <= err_d;
      locked_q     <= locked_d;
    end
  end

  assign sample_l     = sample_l_q;
  assign sample_r     = sample_r_q;
  assign sample_valid = valid_q;
  assign slot_err     = err_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_i2s_rx.sv
// ---------------------------------------------------------------------------
// tb_i2s_rx -- directed self-checking bench for i2s_rx.
// Drives a BCLK = clk/4 I2S stream (Philips format, 24-bit data in 32-bit
// slots, zero padded) and checks output pairs against an expected queue.
// ---------------------------------------------------------------------------
module tb_i2s_rx;

  logic        clk;
  logic        rst;
  logic        bclk;
  logic        lrclk;
  logic        sd;
  logic [23:0] sample_l;
  logic [23:0] sample_r;
  logic        sample_valid;
  logic        slot_err;
  logic        locked;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_err   = 0;
  int cyc     = 0;
  int valid_cyc [16];

  logic [47:0] exp_q [$];

  i2s_rx #(
    .DATA_WIDTH (24),
    .SLOT_BITS  (32),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bclk        (bclk),
    .lrclk       (lrclk),
    .sd          (sd),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .slot_err    (slot_err),
    .locked      (locked)
  );

  // System clock, 10 time units period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter used to measure spacing between valid pulses.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboards every valid pair and every error pulse.
  always @(negedge clk) begin
    if (sample_valid || slot_err) begin
      check_eq("excl", {63'd0, sample_valid & slot_err}, 64'd0);
    end
    if (sample_valid) begin
      if (n_valid < 16) valid_cyc[n_valid] = cyc;
      n_valid++;
      if (exp_q.size() == 0) begin
        check_eq("unexp_valid", {40'd0, sample_l}, 64'hFFFF_FFFF);
      end else begin
        logic [47:0] e;
        e = exp_q.pop_front();
        check_eq("sample_l", {40'd0, sample_l}, {40'd0, e[47:24]});
        check_eq("sample_r", {40'd0, sample_r}, {40'd0, e[23:0]});
        check_eq("locked_on_valid", {63'd0, locked}, 64'd1);
      end
    end
    if (slot_err) begin
      n_err++;
      check_eq("locked_on_err", {63'd0, locked}, 64'd0);
    end
  end

  // One BCLK period: pins change with BCLK low, then BCLK rises.
  task automatic bclk_period(input logic lr, input logic d);
    @(negedge clk);
    bclk  = 1'b0;
    lrclk = lr;
    sd    = d;
    @(negedge clk);
    @(negedge clk);
    bclk = 1'b1;
    @(negedge clk);
  endtask

  // Slot of n periods: period 0 carries the old slot's padding LSB,
  // periods 1..24 carry data MSB first, the rest are zero padding.
  task automatic send_slot_n(input logic lr, input logic [23:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      if (i >= 1 && i <= 24) bclk_period(lr, data[24-i]);
      else                   bclk_period(lr, 1'b0);
    end
  endtask

  task automatic send_frame(input logic [23:0] l, input logic [23:0] r, input bit expect_out);
    if (expect_out) exp_q.push_back({l, r});
    send_slot_n(1'b0, l, 32);
    send_slot_n(1'b1, r, 32);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq(tag, {13'd0, sample_l, sample_r, sample_valid, slot_err, locked}, 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    bclk  = 1'b0;
    lrclk = 1'b0;
    sd    = 1'b0;

    // 1: reset with random pin activity.
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_outputs_zero("reset_outputs");
      bclk  = 1'($urandom_range(1, 0));
      lrclk = 1'($urandom_range(1, 0));
      sd    = 1'($urandom_range(1, 0));
    end
    @(negedge clk);
    bclk  = 1'b0;
    lrclk = 1'b0;
    sd    = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // 2: partial left, arming into a right slot (dropped), then two frames.
    send_slot_n(1'b0, 24'h000000, 10);
    send_slot_n(1'b1, 24'h5A5A5A, 32);
    send_frame(24'h123456, 24'hABCDEF, 1'b1);
    send_frame(24'h123456, 24'hABCDEF, 1'b1);

    // 3: sign extremes.
    send_frame(24'h800000, 24'h7FFFFF, 1'b1);
    send_frame(24'h000001, 24'hFFFFFF, 1'b1);

    // 4: short left slot (31 BCLKs) -> slot_err; its right dropped; recover.
    send_slot_n(1'b0, 24'h111111, 31);
    send_slot_n(1'b1, 24'h222222, 32);
    send_frame(24'h0F0F0F, 24'hF0F0F0, 1'b1);

    // 5: reset at bit 10 of a left slot.
    send_slot_n(1'b0, 24'h333333, 11);
    repeat (4) @(negedge clk);
    check_eq("valid_count_pre_rst", 64'(n_valid), 64'd5);
    check_eq("err_count_pre_rst", 64'(n_err), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check_outputs_zero("mid_frame_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    send_slot_n(1'b0, 24'h333333, 21);
    send_slot_n(1'b1, 24'h444444, 32);
    send_frame(24'hC0FFEE, 24'h00BEEF, 1'b1);
    send_slot_n(1'b0, 24'h000000, 4);
    repeat (8) @(negedge clk);
    check_eq("valid_count_p5", 64'(n_valid), 64'd6);

    // 6: start streaming in a right slot after reset.
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_outputs_zero("p6_after_rst");
    send_slot_n(1'b1, 24'h666666, 32);
    send_frame(24'h765432, 24'h89ABCD, 1'b1);
    send_slot_n(1'b0, 24'h000000, 4);
    repeat (20) @(negedge clk);

    check_eq("total_valid", 64'(n_valid), 64'd7);
    check_eq("total_err", 64'(n_err), 64'd1);
    check_eq("queue_empty", 64'(exp_q.size()), 64'd0);
    check_eq("locked_end", {63'd0, locked}, 64'd1);
    check_eq("hold_l", {40'd0, sample_l}, 64'h765432);
    check_eq("hold_r", {40'd0, sample_r}, 64'h89ABCD);
    check_eq("p2_gap", 64'(valid_cyc[1] - valid_cyc[0]), 64'd256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
